// File: rtl/result_scoreboard_pkg.sv
// Shared definitions for the result scoreboard: verdict state encoding,
// counter width and a saturating increment helper.
package result_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } sb_state_e;

    localparam int CNT_W = 16;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Expected-value FIFO: power-of-two depth, pointers wrap naturally,
// head word is visible combinationally so it can be compared on the pop cycle.
module sb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_data_o = mem_q[rd_ptr_q];

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy next-state; simultaneous push/pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/result_scoreboard.sv
// In-order result scoreboard: queues expected words, compares each measured
// word against the FIFO head, counts tests/failures, latches the first
// mismatch and issues sticky pass/fail verdicts.
module result_scoreboard
    import result_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int NUM_TESTS      = 10,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exp_valid,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  exp_ready,
    input  logic                  meas_valid,
    input  logic [DATA_WIDTH-1:0] meas_data,
    output logic                  meas_ready,
    input  logic                  done_req,
    output logic [CNT_W-1:0]      test_count,
    output logic [CNT_W-1:0]      fail_count,
    output logic                  mismatch,
    output logic [CNT_W-1:0]      first_idx,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic [DATA_WIDTH-1:0] first_meas,
    output logic                  test_passed,
    output logic                  test_failed
);

    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    sb_state_e             state_q, state_d;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push, pop, mism_now;

    logic [CNT_W-1:0]      test_count_q, test_count_d;
    logic [CNT_W-1:0]      fail_count_q, fail_count_d;
    logic [CNT_W-1:0]      first_idx_q, first_idx_d;
    logic [DATA_WIDTH-1:0] first_exp_q, first_exp_d;
    logic [DATA_WIDTH-1:0] first_meas_q, first_meas_d;
    logic                  mismatch_q;
    logic                  passed_q, failed_q;
    logic [TO_W-1:0]       timeout_q, timeout_d;

    assign exp_ready  = !fifo_full;
    assign meas_ready = !fifo_empty && (state_q == ST_RUN);
    assign push       = exp_valid && exp_ready;
    assign pop        = meas_valid && meas_ready;
    assign mism_now   = pop && (head_data != meas_data);

    sb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (exp_data),
        .pop_i       (pop),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Counter and first-mismatch capture; a zero fail count means nothing latched yet.
    always_comb begin
        test_count_d = test_count_q;
        fail_count_d = fail_count_q;
        first_idx_d  = first_idx_q;
        first_exp_d  = first_exp_q;
        first_meas_d = first_meas_q;
        if (pop) begin
            test_count_d = sat_inc(test_count_q);
        end
        if (mism_now) begin
            fail_count_d = sat_inc(fail_count_q);
            if (fail_count_q == '0) begin
                first_idx_d  = test_count_q;
                first_exp_d  = head_data;
                first_meas_d = meas_data;
            end
        end
        timeout_d = (state_q == ST_RUN) ? timeout_q + TO_W'(1) : timeout_q;
    end

    // Verdict next-state: any failure cause wins over a pass request.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (mism_now || (timeout_q == TO_LAST) ||
                (test_count_d > CNT_W'(NUM_TESTS))) begin
                state_d = ST_FAIL;
            end else if (done_req) begin
                if ((test_count_q == CNT_W'(NUM_TESTS)) && (fail_count_q == '0)) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_FAIL;
                end
            end
        end
    end

    // State, counters and verdict flags; verdicts are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            test_count_q <= '0;
            fail_count_q <= '0;
            first_idx_q  <= '0;
            first_exp_q  <= '0;
            first_meas_q <= '0;
            mismatch_q   <= 1'b0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            timeout_q    <= '0;
        end else begin
            state_q      <= state_d;
            test_count_q <= test_count_d;
            fail_count_q <= fail_count_d;
            first_idx_q  <= first_idx_d;
            first_exp_q  <= first_exp_d;
            first_meas_q <= first_meas_d;
            mismatch_q   <= mism_now;
            passed_q     <= (state_d == ST_PASS);
            failed_q     <= (state_d == ST_FAIL);
            timeout_q    <= timeout_d;
        end
    end

    assign test_count  = test_count_q;
    assign fail_count  = fail_count_q;
    assign mismatch    = mismatch_q;
    assign first_idx   = first_idx_q;
    assign first_exp   = first_exp_q;
    assign first_meas  = first_meas_q;
    assign test_passed = passed_q;
    assign test_failed = failed_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed plus randomized bench for result_scoreboard, checked against a
// queue-based reference model of the scoreboard rules.
module tb_result_scoreboard;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NUM   = 10;
    localparam int TO    = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_ready;
    logic          meas_valid = 1'b0;
    logic [DW-1:0] meas_data = '0;
    logic          meas_ready;
    logic          done_req = 1'b0;
    logic [15:0]   test_count, fail_count, first_idx;
    logic          mismatch;
    logic [DW-1:0] first_exp, first_meas;
    logic          test_passed, test_failed;

    always #5 clk = ~clk;

    result_scoreboard #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .NUM_TESTS      (NUM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exp_valid   (exp_valid),
        .exp_data    (exp_data),
        .exp_ready   (exp_ready),
        .meas_valid  (meas_valid),
        .meas_data   (meas_data),
        .meas_ready  (meas_ready),
        .done_req    (done_req),
        .test_count  (test_count),
        .fail_count  (fail_count),
        .mismatch    (mismatch),
        .first_idx   (first_idx),
        .first_exp   (first_exp),
        .first_meas  (first_meas),
        .test_passed (test_passed),
        .test_failed (test_failed)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: 0 = running, 1 = passed, 2 = failed.
    logic [DW-1:0] mq[$];
    int            m_tests, m_fails, m_first_idx, m_state, m_cyc;
    logic [DW-1:0] m_fexp, m_fmeas;
    bit            m_mm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_tests = 0; m_fails = 0; m_first_idx = 0; m_state = 0; m_cyc = 0;
        m_fexp = '0; m_fmeas = '0; m_mm = 1'b0;
    endtask

    function automatic logic [DW-1:0] head_or0();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    task automatic check_outputs();
        chk("test_count",  test_count,  m_tests);
        chk("fail_count",  fail_count,  m_fails);
        chk("mismatch",    mismatch,    m_mm);
        chk("first_idx",   first_idx,   m_first_idx);
        chk("first_exp",   first_exp,   m_fexp);
        chk("first_meas",  first_meas,  m_fmeas);
        chk("test_passed", test_passed, m_state == 1);
        chk("test_failed", test_failed, m_state == 2);
    endtask

    // One clock: drive inputs, check readies, clock, update model, check outputs.
    task automatic step(input bit ev, input logic [DW-1:0] ed, input bit mv,
                        input logic [DW-1:0] md, input bit dr);
        bit            push, pop;
        int            pre_tests, pre_fails;
        logic [DW-1:0] h;
        exp_valid = ev; exp_data = ed; meas_valid = mv; meas_data = md; done_req = dr;
        #1;
        chk("exp_ready",  exp_ready,  mq.size() < DEPTH);
        chk("meas_ready", meas_ready, (mq.size() > 0) && (m_state == 0));
        push = ev && (mq.size() < DEPTH);
        pop  = mv && (mq.size() > 0) && (m_state == 0);
        @(posedge clk);
        #1;
        pre_tests = m_tests;
        pre_fails = m_fails;
        m_mm = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            m_mm = (h !== md);
            if (m_mm && pre_fails == 0) begin
                m_first_idx = pre_tests; m_fexp = h; m_fmeas = md;
            end
            if (m_tests < 65535) m_tests++;
            if (m_mm && m_fails < 65535) m_fails++;
            $display("[TB] compare idx=%0d exp=%h meas=%h %s", pre_tests, h, md,
                     m_mm ? "differs" : "match");
        end
        if (push) mq.push_back(ed);
        if (m_state == 0) begin
            if (m_mm || m_cyc == TO - 1 || m_tests > NUM) m_state = 2;
            else if (dr) m_state = (pre_tests == NUM && pre_fails == 0) ? 1 : 2;
            m_cyc++;
        end
        check_outputs();
        exp_valid = 1'b0; meas_valid = 1'b0; done_req = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        chk("rst_exp_ready",  exp_ready,  1'b1);
        chk("rst_meas_ready", meas_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rise_idx;
        model_clear();
        do_reset();

        // Matching run of exactly NUM compares, then done -> pass.
        $display("[TB] scenario: clean pass");
        for (int i = 0; i < NUM; i++) step(1, DW'(i), 0, '0, 0);
        for (int i = 0; i < NUM; i++) step(0, '0, 1, head_or0(), 0);
        step(0, '0, 0, '0, 1);
        chk("pass_verdict", test_passed, 1'b1);
        chk("pass_no_fail", test_failed, 1'b0);
        chk("pass_count",   test_count,  NUM);
        step(0, '0, 0, '0, 0);

        // Fourth measured word corrupted.
        do_reset();
        $display("[TB] scenario: corrupted word");
        for (int i = 0; i < NUM; i++) step(1, DW'(i), 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, head_or0(), 0);
        step(0, '0, 1, 32'hDEAD, 0);
        chk("corrupt_pulse", mismatch,   1'b1);
        chk("corrupt_idx",   first_idx,  3);
        chk("corrupt_exp",   first_exp,  32'h3);
        chk("corrupt_meas",  first_meas, 32'hDEAD);
        chk("corrupt_fail",  test_failed, 1'b1);
        chk("corrupt_ready", meas_ready, 1'b0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, head_or0(), 0);

        // Fill past depth, drain one, refill, drain in order across the wrap.
        do_reset();
        $display("[TB] scenario: fill and wrap");
        for (int i = 0; i < DEPTH + 2; i++) step(1, 32'h100 + DW'(i), 0, '0, 0);
        chk("full_ready", exp_ready, 1'b0);
        step(0, '0, 1, head_or0(), 0);
        chk("drain_ready", exp_ready, 1'b1);
        step(1, 32'hABCD, 1, head_or0(), 0);
        for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1, head_or0(), 0);

        // Nine compares then done -> count shortfall fails.
        do_reset();
        $display("[TB] scenario: short count");
        for (int i = 0; i < NUM - 1; i++) step(1, $urandom, 1, head_or0(), 0);
        step(0, '0, 1, head_or0(), 0);
        step(0, '0, 0, '0, 1);
        chk("short_fail", test_failed, 1'b1);
        chk("short_pass", test_passed, 1'b0);

        // Mismatch on the tenth compare together with done.
        do_reset();
        $display("[TB] scenario: mismatch with done");
        for (int i = 0; i < NUM; i++) step(1, 32'h50 + DW'(i), 0, '0, 0);
        for (int i = 0; i < NUM - 1; i++) step(0, '0, 1, head_or0(), 0);
        step(0, '0, 1, 32'hBAD0_0000, 1);
        chk("combo_fail",  test_failed, 1'b1);
        chk("combo_pass",  test_passed, 1'b0);
        chk("combo_fails", fail_count,  1);
        chk("combo_tests", test_count,  NUM);

        // Random concurrent traffic with occasional corruption, then done.
        do_reset();
        $display("[TB] scenario: random traffic");
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] md;
            md = head_or0();
            if ($urandom_range(0, 19) == 0) md = md ^ 32'h1;
            step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)), md, 0);
        end
        step(0, '0, 0, '0, 1);

        // Idle run until timeout; verdict must appear at exactly TO cycles.
        do_reset();
        $display("[TB] scenario: timeout");
        rise_idx = -1;
        for (int i = 0; i < TO + 5; i++) begin
            step((i % 50) == 7, DW'(i), 0, '0, 0);
            if (rise_idx < 0 && test_failed === 1'b1) rise_idx = i + 1;
        end
        chk("timeout_cycle", rise_idx, TO);
        step(1, 32'h77, 1, head_or0(), 0);

        // Mid-run reset clears everything without a clock edge.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h9 + DW'(i), 1, head_or0(), 0);
        do_reset();
        step(0, '0, 0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
